// File: rtl/sh_regfile_banked.sv
// sh_regfile_banked: general-register file for the SH core. Low registers are
// replicated per bank, the rest are shared. It has two write ports, two read
// ports, an R0 tap and a sequencer that spills or fills one bank over a stream.
//
// Stream handshake: a beat transfers on a CE-qualified rising edge where valid
// and ready are both high. The producer holds valid, index and data steady
// until that edge. Neither side's valid waits on the other side's ready.
module sh_regfile_banked #(
  parameter int  DW         = 32,
  parameter int  NUM_GR     = 16,
  parameter int  NUM_EXTRA  = 1,
  parameter int  NUM_BANKED = 8,
  parameter int  NUM_BANKS  = 2,
  parameter int  FORWARD    = 0,
  localparam int NT         = NUM_GR + NUM_EXTRA,
  localparam int AW         = (NT > 1) ? $clog2(NT) : 1,
  localparam int BW         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int IW         = (NUM_BANKED > 1) ? $clog2(NUM_BANKED) : 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          CE,
  input  logic [BW-1:0] BANK_SEL,
  input  logic [BW-1:0] ALT_BANK,
  input  logic [AW-1:0] WA_ADDR,
  input  logic [DW-1:0] WA_D,
  input  logic          WAE,
  input  logic          WA_ALT,
  input  logic [AW-1:0] WB_ADDR,
  input  logic [DW-1:0] WB_D,
  input  logic          WBE,
  input  logic [AW-1:0] RA_ADDR,
  input  logic          RA_ALT,
  output logic [DW-1:0] RA_Q,
  input  logic [AW-1:0] RB_ADDR,
  output logic [DW-1:0] RB_Q,
  output logic [DW-1:0] R0_Q,
  input  logic          SPILL_START,
  input  logic          FILL_START,
  input  logic [BW-1:0] SEQ_BANK,
  output logic          SEQ_BUSY,
  output logic          SO_VALID,
  input  logic          SO_READY,
  output logic [IW-1:0] SO_IDX,
  output logic [DW-1:0] SO_D,
  input  logic          FI_VALID,
  output logic          FI_READY,
  input  logic [DW-1:0] FI_D,
  output logic          SEQ_DONE,
  output logic [1:0]    SEQ_STATE
);

  // Physical layout: bank b register i lives at b*NUM_BANKED+i, and the
  // shared registers follow all banks.
  localparam int NPHYS = NUM_BANKS * NUM_BANKED + NT - NUM_BANKED;
  localparam int PW    = (NPHYS > 1) ? $clog2(NPHYS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SPILL = 2'd1,
    S_FILL  = 2'd2,
    S_DONE  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic          ok;
    logic [PW-1:0] p;
  } loc_t;

  logic [DW-1:0] regs [NPHYS];
  seq_state_t    state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bank_q, bank_d;
  loc_t          wa_loc, wb_loc, ra_loc, rb_loc, r0_loc, sq_loc;
  logic          wa_hit, wb_hit, fill_we, cnt_last;
  logic [DW-1:0] ra_raw, rb_raw, r0_raw;

  // Map an architectural index and bank to a physical slot. Out-of-range
  // indices and nonexistent banks come back with ok=0.
  function automatic loc_t decode(input logic [AW-1:0] idx, input logic [BW-1:0] bank);
    loc_t l;
    int   b;
    l.ok = 1'b0;
    l.p  = '0;
    b    = (NUM_BANKS == 1) ? 0 : int'(bank);
    if (int'(idx) < NUM_BANKED) begin
      l.ok = (b < NUM_BANKS);
      l.p  = PW'(b * NUM_BANKED + int'(idx));
    end else if (int'(idx) < NT) begin
      l.ok = 1'b1;
      l.p  = PW'(NUM_BANKS * NUM_BANKED + int'(idx) - NUM_BANKED);
    end
    return l;
  endfunction

  assign wa_loc   = decode(WA_ADDR, WA_ALT ? ALT_BANK : BANK_SEL);
  assign wb_loc   = decode(WB_ADDR, BANK_SEL);
  assign ra_loc   = decode(RA_ADDR, RA_ALT ? ALT_BANK : BANK_SEL);
  assign rb_loc   = decode(RB_ADDR, BANK_SEL);
  assign r0_loc   = decode('0, BANK_SEL);
  assign sq_loc   = decode(AW'(cnt_q), bank_q);
  assign wa_hit   = WAE && wa_loc.ok;
  assign wb_hit   = WBE && wb_loc.ok;
  assign fill_we  = (state_q == S_FILL) && FI_VALID && sq_loc.ok;
  assign cnt_last = (int'(cnt_q) == NUM_BANKED - 1);

  // Replace stored data with this cycle's write data when forwarding is on;
  // port B is checked first because it also wins the array write.
  function automatic logic [DW-1:0] fwd(input loc_t l, input logic [DW-1:0] stored);
    logic [DW-1:0] v;
    v = stored;
    if ((FORWARD != 0) && CE && l.ok) begin
      if (wb_hit && (wb_loc.p == l.p)) v = WB_D;
      else if (wa_hit && (wa_loc.p == l.p)) v = WA_D;
    end
    return v;
  endfunction

  // Combinational read ports with optional same-cycle forwarding.
  always_comb begin
    ra_raw = ra_loc.ok ? regs[ra_loc.p] : '0;
    rb_raw = rb_loc.ok ? regs[rb_loc.p] : '0;
    r0_raw = r0_loc.ok ? regs[r0_loc.p] : '0;
    RA_Q   = fwd(ra_loc, ra_raw);
    RB_Q   = fwd(rb_loc, rb_raw);
    R0_Q   = fwd(r0_loc, r0_raw);
  end

  // Register array. Later assignments win: core port B over port A over the fill.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NPHYS; i++) regs[i] <= '0;
    end else if (CE) begin
      if (fill_we) regs[sq_loc.p] <= FI_D;
      if (wa_hit)  regs[wa_loc.p] <= WA_D;
      if (wb_hit)  regs[wb_loc.p] <= WB_D;
    end
  end

  // Sequencer state, beat counter and latched bank.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bank_q  <= '0;
    end else if (CE) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
    end
  end

  // Sequencer next state; spill has priority over fill when both start together.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    unique case (state_q)
      S_IDLE: begin
        if (SPILL_START) begin
          state_d = S_SPILL;
          cnt_d   = '0;
          bank_d  = SEQ_BANK;
        end else if (FILL_START) begin
          state_d = S_FILL;
          cnt_d   = '0;
          bank_d  = SEQ_BANK;
        end
      end
      S_SPILL: begin
        if (SO_READY) begin
          if (cnt_last) state_d = S_DONE;
          else          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_FILL: begin
        if (FI_VALID) begin
          if (cnt_last) state_d = S_DONE;
          else          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer outputs. Spill data is read live from the array.
  always_comb begin
    SO_VALID  = (state_q == S_SPILL);
    SO_IDX    = SO_VALID ? cnt_q : '0;
    SO_D      = (SO_VALID && sq_loc.ok) ? regs[sq_loc.p] : '0;
    FI_READY  = (state_q == S_FILL);
    SEQ_DONE  = (state_q == S_DONE);
    SEQ_BUSY  = (state_q != S_IDLE);
    SEQ_STATE = state_q;
  end

endmodule

// File: doc/sh_regfile_banked.md
Name: sh_regfile_banked

Overview:
- Parametrised next-generation general-register file for the SH core.
- Two write ports and two read ports, plus a dedicated R0 output; low registers are banked (SH-3/4 style), with an alternate-bank access path.
- Optional write-to-read forwarding.
- Built-in spill/fill sequencer that streams one bank out to, or in from, the context-save logic over a valid/ready handshake.

Parameters:
- DW, 32, data width.
- NUM_GR, 16, architectural general registers R0..R(NUM_GR-1).
- NUM_EXTRA, 1, internal temporaries at indices NUM_GR..NUM_GR+NUM_EXTRA-1; never banked.
- NUM_BANKED, 8, registers R0..R(NUM_BANKED-1) that are replicated per bank; must be <= NUM_GR.
- NUM_BANKS, 2, number of banks; must be >= 1.
- FORWARD, 0, 1 = a same-cycle write appears on read outputs combinationally.
- Derived: AW = clog2(NUM_GR+NUM_EXTRA); BW = max(1, clog2(NUM_BANKS)); IW = max(1, clog2(NUM_BANKED)).

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- CE  in  1  clock enable; gates every state change, including the sequencer.
- BANK_SEL  in  BW  current bank for banked indices.
- ALT_BANK  in  BW  bank used when a port's ALT flag is set.
- WA_ADDR  in  AW  write port A index.
- WA_D  in  DW  write port A data.
- WAE  in  1  write port A enable.
- WA_ALT  in  1  write port A targets ALT_BANK.
- WB_ADDR  in  AW  write port B index.
- WB_D  in  DW  write port B data.
- WBE  in  1  write port B enable.
- RA_ADDR  in  AW  read port A index.
- RA_ALT  in  1  read port A uses ALT_BANK.
- RA_Q  out  DW  read data A.
- RB_ADDR  in  AW  read port B index.
- RB_Q  out  DW  read data B.
- R0_Q  out  DW  R0 of BANK_SEL.
- SPILL_START  in  1  start streaming SEQ_BANK out.
- FILL_START  in  1  start streaming into SEQ_BANK.
- SEQ_BANK  in  BW  bank for the sequencer, sampled at start.
- SEQ_BUSY  out  1  sequencer active.
- SO_VALID  out  1  spill data valid.
- SO_READY  in  1  spill sink ready.
- SO_IDX  out  IW  spill register index.
- SO_D  out  DW  spill data.
- FI_VALID  in  1  fill data valid.
- FI_READY  out  1  fill accept.
- FI_D  in  DW  fill data.
- SEQ_DONE  out  1  one-cycle pulse at end of spill or fill.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous, active-low, on RST_N.
- Reset state:
  - All registers in all banks = 0.
  - Sequencer in IDLE.
  - SEQ_BUSY, SO_VALID, FI_READY, SEQ_DONE, SO_IDX, SO_D all = 0.
  - Reset mid-spill/fill aborts immediately; no SEQ_DONE is produced.
- Address decode:
  - Index < NUM_BANKED maps to bank (ALT ? ALT_BANK : BANK_SEL).
  - Other indices address the shared array.
  - Index >= NUM_GR+NUM_EXTRA: write ignored, read returns 0.
  - Bank value >= NUM_BANKS: write ignored, read returns 0.
- Writes: take effect at the CE-qualified rising edge; the read sees the new value the following cycle.
- Write conflicts:
  - WAE and WBE to the same physical register in one cycle: port B wins.
  - Sequencer fill write vs. core write to the same physical register: core wins (the fill word is still consumed).
- Reads: combinational. With FORWARD=1, a read matching an enabled write target this cycle returns that write data; if both ports match, port B's data is returned. Forwarding applies only when CE=1.
- Sequencer states and transitions:
  - IDLE: SPILL_START -> SPILL; else FILL_START -> FILL. Both asserted: spill wins. Starts are ignored unless in IDLE. SEQ_BANK is latched at start. Index counter := 0.
  - SPILL: SO_VALID=1, SO_IDX=counter, SO_D=bank[counter] (live value, so a concurrent core write is reflected). On SO_VALID & SO_READY, counter+1. On the handshake with counter = NUM_BANKED-1 -> DONE. SO_IDX and SO_D hold stable while SO_READY=0.
  - FILL: FI_READY=1. On FI_VALID & FI_READY, bank[counter] := FI_D, counter+1. On the last index -> DONE.
  - DONE: SEQ_DONE=1 for one cycle, then -> IDLE. SEQ_BUSY=1 in SPILL, FILL and DONE.
- Latency: first SO_VALID appears one cycle after SPILL_START. The minimum spill is NUM_BANKED+1 cycles from start to the SEQ_DONE cycle.
- CE=0: all state frozen; handshakes do not complete, and SO_VALID/FI_READY hold their levels.
- NUM_BANKS=1: ALT flags and bank inputs are ignored.

Test Plan:
- Reset release -> all reads return 0; RA_ADDR=16 after a WAE write of 0xDEADBEEF to index 16 -> RA_Q=0xDEADBEEF next cycle.
- BANK_SEL=0 write R3=0x11; BANK_SEL=1 write R3=0x22; read R3 with BANK_SEL=0 -> 0x11; read with BANK_SEL=1 -> 0x22; RA_ALT=1 with ALT_BANK=0 while BANK_SEL=1 -> 0x11; R8 is identical in both banks.
- WAE and WBE both target R5, with 0xAAAA and 0x5555 -> R5=0x5555; FORWARD=1 with RA_ADDR=5 in the same cycle -> RA_Q=0x5555.
- Bank 1 preloaded with R0..R7=0x10..0x17, SPILL_START with SEQ_BANK=1, SO_READY toggled 1,0,1... -> 8 beats, SO_IDX 0..7 with data 0x10..0x17, values stable while stalled, single SEQ_DONE.
- FILL_START with SEQ_BANK=0, eight FI_D beats 0x100..0x107 with FI_VALID gaps; a core write of R2=0x999 in the same cycle as the fill of index 2 -> final R2=0x999, other registers = 0x10n.
- RST_N asserted during beat 3 of a spill -> SEQ_BUSY=0 and SO_VALID=0 immediately, registers=0, no SEQ_DONE.
